// File: rtl/rr_arbiter8.sv
// rr_arbiter8: eight-requester round-robin arbiter with a registered index/one-hot grant.
// The grant is held until done, until the owner withdraws its request, or, when the
// RR_ARB8_TIMEOUT_EN macro is defined, until MAX_HOLD grant cycles have elapsed.
// The default build has no hold counter, and tmo is constant 0.
module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  input  logic       done,
  output logic       gnt_vld,
  output logic [2:0] gnt_idx,
  output logic [7:0] gnt,
  output logic       tmo
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state;
  logic [2:0] ptr;
  logic [7:0] rot;
  logic [2:0] off;
  logic [2:0] win;
  logic [7:0] win_oh;
  logic       any;
  logic       hold_exp;
  logic       rel;

  // Rotate requests so that ptr sits at bit 0, take the lowest set bit, then rotate back.
  always_comb begin
    rot = 8'({req, req} >> ptr);
    any = |req;
    off = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (rot[i]) off = 3'(i);
    win = ptr + off;
  end

  // One-hot decode of the winner, so that gnt is loaded on the same edge as gnt_idx.
  for (genvar i = 0; i < 8; i++) begin : g_dec
    assign win_oh[i] = (win == 3'(i));
  end

`ifdef RR_ARB8_TIMEOUT_EN
  logic [7:0] hold_cnt;

  assign hold_exp = (hold_cnt == 8'(MAX_HOLD - 1));

  // The hold counter sits at 0 while idle and counts grant cycles. tmo flags a forced drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= 8'd0;
      tmo      <= 1'b0;
    end else begin
      tmo      <= (state == GRANT) && hold_exp;
      hold_cnt <= (state == GRANT) ? hold_cnt + 8'd1 : 8'd0;
    end
  end
`else
  assign hold_exp = 1'b0;
  assign tmo      = 1'b0;
`endif

  // Release causes are ORed: done, owner withdrawal, or an expired hold.
  assign rel = done | ~req[gnt_idx] | hold_exp;

  // Two-state FSM. Outputs are registered, and gnt_idx and ptr survive a release.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= 3'd0;
      gnt_vld <= 1'b0;
      gnt_idx <= 3'd0;
      gnt     <= 8'd0;
    end else begin
      case (state)
        IDLE: if (en && any) begin
          state   <= GRANT;
          gnt_vld <= 1'b1;
          gnt_idx <= win;
          gnt     <= win_oh;
          ptr     <= win + 3'd1;
        end
        GRANT: if (rel) begin
          state   <= IDLE;
          gnt_vld <= 1'b0;
          gnt     <= 8'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: scenario tasks drive rr_arbiter8 one cycle at a time. Each step pushes
// the expected {gnt_vld, gnt_idx, gnt, tmo} into a scoreboard and then pops it after the edge.
module tb_rr_arbiter8;

`ifdef RR_ARB8_TIMEOUT_EN
  localparam int MH = 4;
`else
  localparam int MH = 16;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic       gnt_vld;
  logic [2:0] gnt_idx;
  logic [7:0] gnt;
  logic       tmo;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        rst;
    logic        en;
    logic [7:0]  req;
    logic        done;
    logic [12:0] exp;
  } step_t;

  logic [12:0] sb[$];

  rr_arbiter8 #(.MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .done(done),
    .gnt_vld(gnt_vld), .gnt_idx(gnt_idx), .gnt(gnt), .tmo(tmo)
  );

  always #5 clk = ~clk;

  // Expected output word: {vld, idx, one-hot gnt, tmo}.
  function automatic logic [12:0] ex(input logic v, input int idx, input logic t);
    logic [7:0] oh;
    oh = v ? (8'b1 << idx) : 8'h00;
    return {v, 3'(idx), oh, t};
  endfunction

  function automatic step_t mk(input logic r, input logic e, input logic [7:0] q,
                               input logic d, input logic v, input int idx, input logic t);
    step_t s;
    s.rst = r; s.en = e; s.req = q; s.done = d; s.exp = ex(v, idx, t);
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step_t st[$];
    logic [12:0] e;
    st.push_back(mk(1, 1, 8'hFF, 0, 0, 0, 0));
    st.push_back(mk(1, 1, 8'hFF, 0, 0, 0, 0));
    st.push_back(mk(0, 1, 8'hFF, 0, 1, 0, 0));
    st.push_back(mk(0, 1, 8'hFF, 1, 0, 0, 0));
    foreach (st[k]) begin
      rst = st[k].rst; en = st[k].en; req = st[k].req; done = st[k].done;
      sb.push_back(st[k].exp);
      tick();
      e = sb.pop_front();
      checks++;
      if ({gnt_vld, gnt_idx, gnt, tmo} !== e) begin
        failures++;
        $display("FAIL reset step%0d got=%h exp=%h", k, {gnt_vld, gnt_idx, gnt, tmo}, e);
      end
    end
  endtask

  task automatic test_rotation();
    step_t st[$];
    logic [12:0] e;
    st.push_back(mk(1, 1, 8'hFF, 0, 0, 0, 0));
    for (int k = 0; k < 9; k++) begin
      st.push_back(mk(0, 1, 8'hFF, 0, 1, k % 8, 0));
      st.push_back(mk(0, 1, 8'hFF, 1, 0, k % 8, 0));
    end
    foreach (st[k]) begin
      rst = st[k].rst; en = st[k].en; req = st[k].req; done = st[k].done;
      sb.push_back(st[k].exp);
      tick();
      e = sb.pop_front();
      checks++;
      if ({gnt_vld, gnt_idx, gnt, tmo} !== e) begin
        failures++;
        $display("FAIL rotation step%0d got=%h exp=%h", k, {gnt_vld, gnt_idx, gnt, tmo}, e);
      end
    end
  endtask

  task automatic test_wrap_skip();
    step_t st[$];
    logic [12:0] e;
    st.push_back(mk(1, 1, 8'h40, 0, 0, 0, 0));
    st.push_back(mk(0, 1, 8'h40, 0, 1, 6, 0));
    st.push_back(mk(0, 1, 8'h40, 1, 0, 6, 0));
    st.push_back(mk(0, 1, 8'h21, 0, 1, 0, 0));
    st.push_back(mk(0, 1, 8'h21, 1, 0, 0, 0));
    st.push_back(mk(0, 1, 8'h21, 0, 1, 5, 0));
    st.push_back(mk(0, 1, 8'h21, 1, 0, 5, 0));
    foreach (st[k]) begin
      rst = st[k].rst; en = st[k].en; req = st[k].req; done = st[k].done;
      sb.push_back(st[k].exp);
      tick();
      e = sb.pop_front();
      checks++;
      if ({gnt_vld, gnt_idx, gnt, tmo} !== e) begin
        failures++;
        $display("FAIL wrap_skip step%0d got=%h exp=%h", k, {gnt_vld, gnt_idx, gnt, tmo}, e);
      end
    end
  endtask

  // Starts with ptr = 6 left by test_wrap_skip.
  task automatic test_withdraw_enable();
    step_t st[$];
    logic [12:0] e;
    st.push_back(mk(0, 1, 8'h08, 0, 1, 3, 0));
    st.push_back(mk(0, 1, 8'h00, 0, 0, 3, 0));
    st.push_back(mk(0, 0, 8'h10, 0, 0, 3, 0));
    st.push_back(mk(0, 0, 8'h10, 0, 0, 3, 0));
    st.push_back(mk(0, 1, 8'h10, 0, 1, 4, 0));
    st.push_back(mk(0, 0, 8'h10, 0, 1, 4, 0));
    st.push_back(mk(0, 0, 8'h10, 0, 1, 4, 0));
    st.push_back(mk(0, 0, 8'h10, 1, 0, 4, 0));
    st.push_back(mk(0, 1, 8'h20, 0, 1, 5, 0));
    st.push_back(mk(0, 1, 8'h00, 1, 0, 5, 0));
    st.push_back(mk(0, 1, 8'h00, 0, 0, 5, 0));
    foreach (st[k]) begin
      rst = st[k].rst; en = st[k].en; req = st[k].req; done = st[k].done;
      sb.push_back(st[k].exp);
      tick();
      e = sb.pop_front();
      checks++;
      if ({gnt_vld, gnt_idx, gnt, tmo} !== e) begin
        failures++;
        $display("FAIL withdraw_enable step%0d got=%h exp=%h", k, {gnt_vld, gnt_idx, gnt, tmo}, e);
      end
    end
  endtask

  task automatic test_timeout();
    step_t st[$];
    logic [12:0] e;
    st.push_back(mk(1, 1, 8'h02, 0, 0, 0, 0));
`ifdef RR_ARB8_TIMEOUT_EN
    for (int k = 0; k < MH; k++) st.push_back(mk(0, 1, 8'h02, 0, 1, 1, 0));
    st.push_back(mk(0, 1, 8'h02, 0, 0, 1, 1));
    for (int k = 0; k < MH; k++) st.push_back(mk(0, 1, 8'h02, 0, 1, 1, 0));
    st.push_back(mk(0, 1, 8'h02, 1, 0, 1, 1));
    st.push_back(mk(0, 1, 8'h00, 0, 0, 1, 0));
`else
    for (int k = 0; k < 120; k++) st.push_back(mk(0, 1, 8'h02, 0, 1, 1, 0));
    st.push_back(mk(0, 1, 8'h02, 1, 0, 1, 0));
`endif
    foreach (st[k]) begin
      rst = st[k].rst; en = st[k].en; req = st[k].req; done = st[k].done;
      sb.push_back(st[k].exp);
      tick();
      e = sb.pop_front();
      checks++;
      if ({gnt_vld, gnt_idx, gnt, tmo} !== e) begin
        failures++;
        $display("FAIL timeout step%0d got=%h exp=%h", k, {gnt_vld, gnt_idx, gnt, tmo}, e);
      end
    end
  endtask

  // A grant from ptr = 0 with req = 8'h60 goes to 5. Any stale ptr of 6 would pick 6 instead.
  task automatic test_reset_mid();
    step_t st[$];
    logic [12:0] e;
    st.push_back(mk(1, 1, 8'h20, 0, 0, 0, 0));
    st.push_back(mk(0, 1, 8'h20, 0, 1, 5, 0));
    st.push_back(mk(1, 1, 8'h20, 0, 0, 0, 0));
    st.push_back(mk(0, 1, 8'h60, 0, 1, 5, 0));
    st.push_back(mk(1, 1, 8'h60, 0, 0, 0, 0));
    st.push_back(mk(0, 1, 8'h21, 0, 1, 0, 0));
    st.push_back(mk(0, 1, 8'h21, 1, 0, 0, 0));
    foreach (st[k]) begin
      rst = st[k].rst; en = st[k].en; req = st[k].req; done = st[k].done;
      sb.push_back(st[k].exp);
      tick();
      e = sb.pop_front();
      checks++;
      if ({gnt_vld, gnt_idx, gnt, tmo} !== e) begin
        failures++;
        $display("FAIL reset_mid step%0d got=%h exp=%h", k, {gnt_vld, gnt_idx, gnt, tmo}, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_wrap_skip();
    test_withdraw_enable();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
